// File: rtl/logo_key_gen_pkg.sv
// logo_key_gen_pkg
//   Shared types and constants for the logo key generator.
//   - DATA_W  : video / alpha / key sample width
//   - KEY_MAX : full-scale key (1023 = pure live video, logo fully hidden)
//   - ROM_W   : logo ROM word width, {pixel, alpha}
//   - fade_state_e : fade controller states
package logo_key_gen_pkg;

  localparam int DATA_W = 10;
  localparam int ROM_W  = 2 * DATA_W;
  localparam logic [DATA_W-1:0] KEY_MAX = 10'd1023;

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    ON,
    FADE_OUT
  } fade_state_e;

endpackage

// File: rtl/logo_key_gen_if.sv
// logo_key_gen_if
//   Bus to the external synchronous logo ROM.
//   - rom_rd   : read enable
//   - rom_addr : read address
//   - rom_data : {pixel[19:10], alpha[9:0]}, valid one clock after rom_addr/rom_rd
//   master = logo_key_gen side, slave = ROM side.
interface logo_key_gen_if #(
  parameter int ADDR_W = 13
);

  logic                                rom_rd;
  logic [ADDR_W-1:0]                   rom_addr;
  logic [logo_key_gen_pkg::ROM_W-1:0]  rom_data;

  modport master (
    output rom_rd,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_rd,
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/logo_key_gen_fade.sv
// logo_fade_ctrl
//   Frame-stepped logo opacity controller. The level only moves on a frame
//   start (vs_rise), so it is constant across every pixel of a frame.
//   Ports:
//   - clk, rst   : clock, synchronous active-high reset
//   - vs_rise    : one-cycle frame-start strobe
//   - logo_en    : level request, logo visible
//   - fade_level : current opacity 0..1023
//   - fade_busy  : high while fading in or out
module logo_fade_ctrl
  import logo_key_gen_pkg::*;
#(
  parameter int FADE_STEP = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_rise,
  input  logic              logo_en,
  output logic [DATA_W-1:0] fade_level,
  output logic              fade_busy
);

  localparam logic [DATA_W:0]   STEP_W = (DATA_W + 1)'(FADE_STEP);
  localparam logic [DATA_W:0]   FULL_W = {1'b0, KEY_MAX};
  localparam logic [DATA_W-1:0] STEP   = DATA_W'(FADE_STEP);

  fade_state_e       state_q, state_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic              busy_q,  busy_d;
  logic [DATA_W:0]   up_sum;
  logic              up_full;
  logic              down_empty;

  always_comb begin
    up_sum     = {1'b0, level_q} + STEP_W;
    up_full    = (up_sum >= FULL_W);
    down_empty = ({1'b0, level_q} <= STEP_W);
    state_d    = state_q;
    level_d    = level_q;
    // Ramps always continue from the current level, so a reversal mid-fade
    // never jumps.
    if (vs_rise) begin
      if (logo_en && (state_q != ON)) begin
        if (up_full) begin
          state_d = ON;
          level_d = KEY_MAX;
        end else begin
          state_d = FADE_IN;
          level_d = up_sum[DATA_W-1:0];
        end
      end else if (!logo_en && (state_q != IDLE)) begin
        if (down_empty) begin
          state_d = IDLE;
          level_d = '0;
        end else begin
          state_d = FADE_OUT;
          level_d = level_q - STEP;
        end
      end
    end
    busy_d = (state_d == FADE_IN) || (state_d == FADE_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign fade_level = level_q;
  assign fade_busy  = busy_q;

endmodule

// File: rtl/logo_key_gen.sv
// logo_key_gen
//   Feeds the 10-bit key mixer: tracks raster position, fetches logo pixel and
//   alpha from an external ROM inside a fixed window, and emits live video,
//   logo sample and key, all delayed exactly 3 clocks from the inputs.
//   Ports:
//   - clk, rst            : clock, synchronous active-high reset
//   - de_in, vs_in        : pixel strobe, vertical sync (rising edge = frame start)
//   - data_in             : live video sample
//   - logo_en             : logo requested visible
//   - rom                 : ROM read bus (master)
//   - data_a_out          : delayed live video
//   - data_b_out          : logo pixel, 0 outside window
//   - key_out             : mixer key, 1023 = pure live video
//   - de_out, vs_out      : delayed strobes
//   - fade_busy           : fade in progress
module logo_key_gen
  import logo_key_gen_pkg::*;
#(
  parameter int LOGO_X    = 64,
  parameter int LOGO_Y    = 32,
  parameter int LOGO_W    = 128,
  parameter int LOGO_H    = 64,
  parameter int ADDR_W    = 13,
  parameter int FADE_STEP = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              vs_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              logo_en,
  logo_key_gen_if.master    rom,
  output logic [DATA_W-1:0] data_a_out,
  output logic [DATA_W-1:0] data_b_out,
  output logic [DATA_W-1:0] key_out,
  output logic              de_out,
  output logic              vs_out,
  output logic              fade_busy
);

  localparam int POS_W = 12;
  localparam logic [POS_W-1:0]  X_LO     = POS_W'(LOGO_X);
  localparam logic [POS_W-1:0]  X_HI     = POS_W'(LOGO_X + LOGO_W);
  localparam logic [POS_W-1:0]  Y_LO     = POS_W'(LOGO_Y);
  localparam logic [POS_W-1:0]  Y_HI     = POS_W'(LOGO_Y + LOGO_H);
  localparam logic [POS_W-1:0]  POS_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Logo opacity for one pixel; the end points bypass the multiplier so that
  // full fade gives exactly alpha and zero fade gives exactly 0.
  function automatic logic [DATA_W-1:0] opacity(input logic [DATA_W-1:0] alpha,
                                                input logic [DATA_W-1:0] level);
    logic [2*DATA_W-1:0] prod;
    prod = alpha * level;
    if (level == KEY_MAX)  return alpha;
    else if (level == '0)  return '0;
    else                   return prod[2*DATA_W-1:DATA_W];
  endfunction

  logic              vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_valid_q, frame_valid_d;
  logic              vs_rise, de_fall, hit;
  logic [DATA_W-1:0] fade_level;
  logic [DATA_W-1:0] rom_pix, rom_alpha;

  logic              vld_p0_q, vld_p0_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] data_a_p0_q, data_a_p0_d;
  logic              de_p0_q, de_p0_d, vs_p0_q, vs_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_a_p1_q, data_a_p1_d;
  logic              de_p1_q, de_p1_d, vs_p1_q, vs_p1_d;
  logic [DATA_W-1:0] data_a_out_q, data_a_out_d, data_b_out_q, data_b_out_d;
  logic [DATA_W-1:0] key_out_q, key_out_d;
  logic              de_out_q, de_out_d, vs_out_q, vs_out_d;

  assign vs_rise   = vs_in && !vs_prev_q;
  assign de_fall   = de_prev_q && !de_in;
  assign hit       = frame_valid_q && de_in && (x_q >= X_LO) && (x_q < X_HI) &&
                     (y_q >= Y_LO) && (y_q < Y_HI);
  assign rom_pix   = rom.rom_data[2*DATA_W-1:DATA_W];
  assign rom_alpha = rom.rom_data[DATA_W-1:0];

  logo_fade_ctrl #(
    .FADE_STEP (FADE_STEP)
  ) u_fade (
    .clk        (clk),
    .rst        (rst),
    .vs_rise    (vs_rise),
    .logo_en    (logo_en),
    .fade_level (fade_level),
    .fade_busy  (fade_busy)
  );

  always_comb begin
    vs_prev_d     = vs_in;
    de_prev_d     = de_in;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    frame_valid_d = frame_valid_q;
    if (vs_rise) begin
      x_d           = '0;
      y_d           = '0;
      addr_d        = '0;
      frame_valid_d = 1'b1;
    end else begin
      // Counters hold at full scale rather than wrapping into the window.
      if (de_in) begin
        x_d = (x_q == POS_MAX) ? x_q : x_q + 1'b1;
      end else if (de_fall) begin
        x_d = '0;
        y_d = (y_q == POS_MAX) ? y_q : y_q + 1'b1;
      end
      if (hit) addr_d = (addr_q == ADDR_MAX) ? addr_q : addr_q + 1'b1;
    end

    // p0: ROM request issued, live sample and hit flag enter the pipe
    vld_p0_d     = hit;
    rom_addr_d   = addr_q;
    data_a_p0_d  = data_in;
    de_p0_d      = de_in;
    vs_p0_d      = vs_in;

    // p1: wait for ROM data
    vld_p1_d     = vld_p0_q;
    data_a_p1_d  = data_a_p0_q;
    de_p1_d      = de_p0_q;
    vs_p1_d      = vs_p0_q;

    // p2: ROM data valid, form logo sample and key
    data_a_out_d = data_a_p1_q;
    de_out_d     = de_p1_q;
    vs_out_d     = vs_p1_q;
    data_b_out_d = vld_p1_q ? rom_pix : '0;
    key_out_d    = vld_p1_q ? (KEY_MAX - opacity(rom_alpha, fade_level)) : KEY_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      frame_valid_q <= 1'b0;
      vld_p0_q      <= 1'b0;
      rom_addr_q    <= '0;
      data_a_p0_q   <= '0;
      de_p0_q       <= 1'b0;
      vs_p0_q       <= 1'b0;
      vld_p1_q      <= 1'b0;
      data_a_p1_q   <= '0;
      de_p1_q       <= 1'b0;
      vs_p1_q       <= 1'b0;
      data_a_out_q  <= '0;
      data_b_out_q  <= '0;
      key_out_q     <= KEY_MAX;
      de_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
    end else begin
      vs_prev_q     <= vs_prev_d;
      de_prev_q     <= de_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      frame_valid_q <= frame_valid_d;
      vld_p0_q      <= vld_p0_d;
      rom_addr_q    <= rom_addr_d;
      data_a_p0_q   <= data_a_p0_d;
      de_p0_q       <= de_p0_d;
      vs_p0_q       <= vs_p0_d;
      vld_p1_q      <= vld_p1_d;
      data_a_p1_q   <= data_a_p1_d;
      de_p1_q       <= de_p1_d;
      vs_p1_q       <= vs_p1_d;
      data_a_out_q  <= data_a_out_d;
      data_b_out_q  <= data_b_out_d;
      key_out_q     <= key_out_d;
      de_out_q      <= de_out_d;
      vs_out_q      <= vs_out_d;
    end
  end

  assign rom.rom_rd   = vld_p0_q;
  assign rom.rom_addr = rom_addr_q;
  assign data_a_out   = data_a_out_q;
  assign data_b_out   = data_b_out_q;
  assign key_out      = key_out_q;
  assign de_out       = de_out_q;
  assign vs_out       = vs_out_q;

endmodule

// File: tb/tb_logo_key_gen.sv
// tb_logo_key_gen
//   Directed bench for logo_key_gen with a behavioural synchronous logo ROM.
module tb_logo_key_gen;

  logic       clk, rst, de_in, vs_in, logo_en;
  logic [9:0] data_in, data_a_out, data_b_out, key_out;
  logic       de_out, vs_out, fade_busy;
  logic [9:0] rom_pix, rom_alpha;

  int errors = 0;
  int checks = 0;

  // Input history: index 2 is the input whose result is on the outputs now.
  logic [9:0] h_data [3];
  logic       h_de [3], h_vs [3], h_hit [3];
  int         h_tag [3];

  // Values captured on line 32 of a probe frame (tags are pixel columns).
  logic [9:0]  cap_key, cap_edge, cap_pix;
  logic [12:0] cap_addr;

  logo_key_gen_if #(.ADDR_W(13)) rom_if ();

  logo_key_gen #(
    .LOGO_X(64), .LOGO_Y(32), .LOGO_W(128), .LOGO_H(64), .ADDR_W(13), .FADE_STEP(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .de_in      (de_in),
    .vs_in      (vs_in),
    .data_in    (data_in),
    .logo_en    (logo_en),
    .rom        (rom_if),
    .data_a_out (data_a_out),
    .data_b_out (data_b_out),
    .key_out    (key_out),
    .de_out     (de_out),
    .vs_out     (vs_out),
    .fade_busy  (fade_busy)
  );

  always @(posedge clk) begin
    if (rst) rom_if.rom_data <= '0;
    else if (rom_if.rom_rd) rom_if.rom_data <= {rom_pix, rom_alpha};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ramp_key(input int f);
    // alpha = 1023, f a multiple of 32 below 1023: op = f - 1
    if (f >= 1023) return 10'd0;
    if (f <= 0)    return 10'd1023;
    return 10'(1024 - f);
  endfunction

  task automatic drive(input logic de, input logic vs, input logic [9:0] d,
                       input logic hit, input int tag);
    for (int i = 2; i > 0; i--) begin
      h_data[i] = h_data[i-1]; h_de[i] = h_de[i-1]; h_vs[i] = h_vs[i-1];
      h_hit[i]  = h_hit[i-1];  h_tag[i] = h_tag[i-1];
    end
    h_data[0] = d; h_de[0] = de; h_vs[0] = vs; h_hit[0] = hit; h_tag[0] = tag;
    de_in = de; vs_in = vs; data_in = d;
    @(posedge clk); #1;
    if (h_tag[0] == 64) cap_addr = rom_if.rom_addr;
    if (h_tag[2] == 63) cap_edge = key_out;
    if (h_tag[2] == 64) begin cap_key = key_out; cap_pix = data_b_out; end
  endtask

  task automatic frame_start();
    drive(1'b0, 1'b1, 10'd0, 1'b0, -1);
    drive(1'b0, 1'b1, 10'd0, 1'b0, -1);
    drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
  endtask

  // Short frame: 32 one-pixel lines, then line 32 from x=0 to x=64 (one hit).
  task automatic probe_frame(output logic busy);
    cap_key = 'x; cap_edge = 'x; cap_pix = 'x; cap_addr = 'x;
    frame_start();
    busy = fade_busy;
    for (int ly = 0; ly < 32; ly++) begin
      drive(1'b1, 1'b0, 10'(ly), 1'b0, -1);
      drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
    end
    for (int lx = 0; lx <= 64; lx++) drive(1'b1, 1'b0, 10'(lx), lx == 64, lx);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
    drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
    checks++; if (key_out !== 10'd1023) begin errors++; $display("FAIL rst_key: got %0d expected 1023", key_out); end
    checks++; if (data_a_out !== 10'd0) begin errors++; $display("FAIL rst_data_a: got %0d expected 0", data_a_out); end
    checks++; if (data_b_out !== 10'd0) begin errors++; $display("FAIL rst_data_b: got %0d expected 0", data_b_out); end
    checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL rst_de_out: got %0b expected 0", de_out); end
    checks++; if (vs_out !== 1'b0) begin errors++; $display("FAIL rst_vs_out: got %0b expected 0", vs_out); end
    checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL rst_fade_busy: got %0b expected 0", fade_busy); end
    checks++; if (rom_if.rom_rd !== 1'b0) begin errors++; $display("FAIL rst_rom_rd: got %0b expected 0", rom_if.rom_rd); end
    checks++; if (rom_if.rom_addr !== 13'd0) begin errors++; $display("FAIL rst_rom_addr: got %0d expected 0", rom_if.rom_addr); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
      checks++;
      if ({key_out, data_b_out, de_out, rom_if.rom_rd} !== {10'd1023, 10'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_outputs: key=%0d data_b=%0d de_out=%0b rom_rd=%0b expected 1023/0/0/0",
                 key_out, data_b_out, de_out, rom_if.rom_rd);
      end
    end
  endtask

  // 80x40 raster (4 blank cycles per line), logo off: video passes 3 clks late.
  task automatic test_video_delay();
    logic de, vs, hit;
    int m, x, y;
    logo_en = 1'b0; rom_pix = 10'd321; rom_alpha = 10'd1023;
    for (int n = 0; n < 3 + 40 * 84 + 3; n++) begin
      de = 1'b0; vs = (n < 2); hit = 1'b0;
      m = n - 3;
      if (n >= 3 && m < 40 * 84) begin
        y = m / 84; x = m % 84;
        de  = (x < 80);
        hit = de && (x >= 64) && (y >= 32);
      end
      drive(de, vs, 10'(n * 7), hit, -1);
      checks++;
      if ({data_a_out, de_out, vs_out} !== {h_data[2], h_de[2], h_vs[2]}) begin
        errors++;
        $display("FAIL delay_align: got data_a=%0d de=%0b vs=%0b expected %0d/%0b/%0b",
                 data_a_out, de_out, vs_out, h_data[2], h_de[2], h_vs[2]);
      end
      checks++;
      if (key_out !== 10'd1023) begin errors++; $display("FAIL delay_key: got %0d expected 1023", key_out); end
      checks++;
      if (data_b_out !== (h_hit[2] ? 10'd321 : 10'd0)) begin
        errors++; $display("FAIL delay_data_b: got %0d expected %0d", data_b_out, h_hit[2] ? 321 : 0);
      end
    end
  endtask

  task automatic test_on_window();
    logic de, hit, busy;
    int exp_addr;
    logo_en = 1'b1; rom_pix = 10'd500; rom_alpha = 10'd1023;
    for (int f = 0; f < 32; f++) frame_start();
    checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL on_busy: got %0b expected 0", fade_busy); end
    frame_start();
    exp_addr = 0;
    for (int y = 0; y < 96; y++) begin
      for (int x = 0; x < 196; x++) begin
        de  = (x < 192);
        hit = de && (x >= 64) && (y >= 32);
        drive(de, 1'b0, 10'(x + y), hit, -1);
        checks++;
        if (key_out !== (h_hit[2] ? 10'd0 : 10'd1023)) begin
          errors++; $display("FAIL on_key: got %0d expected %0d", key_out, h_hit[2] ? 0 : 1023);
        end
        checks++;
        if (data_b_out !== (h_hit[2] ? 10'd500 : 10'd0)) begin
          errors++; $display("FAIL on_data_b: got %0d expected %0d", data_b_out, h_hit[2] ? 500 : 0);
        end
        checks++;
        if (rom_if.rom_rd !== hit) begin errors++; $display("FAIL on_rom_rd: got %0b expected %0b", rom_if.rom_rd, hit); end
        if (hit) begin
          checks++;
          if (rom_if.rom_addr !== 13'(exp_addr)) begin
            errors++; $display("FAIL on_rom_addr: got %0d expected %0d", rom_if.rom_addr, exp_addr);
          end
          exp_addr++;
        end
        if (x == 64 && y == 32) begin
          checks++; if (rom_if.rom_addr !== 13'd0) begin errors++; $display("FAIL first_addr: got %0d expected 0", rom_if.rom_addr); end
        end
        if (x == 191 && y == 95) begin
          checks++; if (rom_if.rom_addr !== 13'd8191) begin errors++; $display("FAIL last_addr: got %0d expected 8191", rom_if.rom_addr); end
        end
      end
    end
    rom_alpha = 10'd512;
    probe_frame(busy);
    checks++; if (cap_key !== 10'd511) begin errors++; $display("FAIL on_alpha512_key: got %0d expected 511", cap_key); end
    checks++; if (cap_edge !== 10'd1023) begin errors++; $display("FAIL on_edge_key: got %0d expected 1023", cap_edge); end
    checks++; if (cap_pix !== 10'd500) begin errors++; $display("FAIL on_pix: got %0d expected 500", cap_pix); end
    // Drop request from ON: level 991, op = (512*991)>>10 = 495.
    logo_en = 1'b0;
    probe_frame(busy);
    checks++; if (cap_key !== 10'd528) begin errors++; $display("FAIL on_drop_key: got %0d expected 528", cap_key); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL on_drop_busy: got %0b expected 1", busy); end
  endtask

  task automatic test_fade_ramp();
    logic busy;
    int f;
    do_reset();
    logo_en = 1'b1; rom_alpha = 10'd1023; rom_pix = 10'd77;
    for (int k = 1; k <= 32; k++) begin
      probe_frame(busy);
      f = (k * 32 > 1023) ? 1023 : k * 32;
      checks++; if (cap_key !== ramp_key(f)) begin errors++; $display("FAIL ramp_key: frame %0d got %0d expected %0d", k, cap_key, ramp_key(f)); end
      checks++; if (busy !== (k < 32)) begin errors++; $display("FAIL ramp_busy: frame %0d got %0b expected %0b", k, busy, k < 32); end
      checks++; if (cap_edge !== 10'd1023) begin errors++; $display("FAIL ramp_edge: frame %0d got %0d expected 1023", k, cap_edge); end
      checks++; if (cap_addr !== 13'd0) begin errors++; $display("FAIL ramp_addr: frame %0d got %0d expected 0", k, cap_addr); end
    end
  endtask

  task automatic test_fade_out();
    logic busy;
    int f;
    do_reset();
    logo_en = 1'b1; rom_alpha = 10'd1023;
    for (int k = 0; k < 10; k++) probe_frame(busy);
    checks++; if (cap_key !== 10'd704) begin errors++; $display("FAIL fade_320: got %0d expected 704", cap_key); end
    logo_en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      probe_frame(busy);
      f = 320 - 32 * j;
      checks++; if (cap_key !== ramp_key(f)) begin errors++; $display("FAIL fadeout_key: step %0d got %0d expected %0d", j, cap_key, ramp_key(f)); end
      checks++; if (busy !== (f != 0)) begin errors++; $display("FAIL fadeout_busy: step %0d got %0b expected %0b", j, busy, f != 0); end
    end
    probe_frame(busy);
    checks++; if ({cap_key, busy} !== {10'd1023, 1'b0}) begin errors++; $display("FAIL idle_hold: key=%0d busy=%0b expected 1023/0", cap_key, busy); end
    logo_en = 1'b1;
    for (int k = 0; k < 4; k++) probe_frame(busy);
    checks++; if (cap_key !== 10'd896) begin errors++; $display("FAIL fade_128: got %0d expected 896", cap_key); end
    logo_en = 1'b0;
    probe_frame(busy);
    checks++; if ({cap_key, busy} !== {10'd928, 1'b1}) begin errors++; $display("FAIL fade_96: key=%0d busy=%0b expected 928/1", cap_key, busy); end
    logo_en = 1'b1;
    probe_frame(busy);
    checks++; if ({cap_key, busy} !== {10'd896, 1'b1}) begin errors++; $display("FAIL reassert_128: key=%0d busy=%0b expected 896/1", cap_key, busy); end
  endtask

  // Reset lands mid-line inside the window while fading in at level 160.
  task automatic test_reset_mid();
    logic busy;
    frame_start();
    for (int ly = 0; ly < 32; ly++) begin
      drive(1'b1, 1'b0, 10'd5, 1'b0, -1);
      drive(1'b0, 1'b0, 10'd0, 1'b0, -1);
    end
    for (int lx = 0; lx < 68; lx++) drive(1'b1, 1'b0, 10'(lx), lx >= 64, lx);
    checks++; if (cap_key !== 10'd864) begin errors++; $display("FAIL pre_rst_key: got %0d expected 864", cap_key); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 10'd68, 1'b0, -1);
    rst = 1'b0;
    checks++;
    if ({key_out, data_a_out, data_b_out, de_out, vs_out, fade_busy, rom_if.rom_rd, rom_if.rom_addr} !==
        {10'd1023, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'd0}) begin
      errors++;
      $display("FAIL mid_rst_outputs: key=%0d a=%0d b=%0d de=%0b vs=%0b busy=%0b rd=%0b addr=%0d expected 1023/0/0/0/0/0/0/0",
               key_out, data_a_out, data_b_out, de_out, vs_out, fade_busy, rom_if.rom_rd, rom_if.rom_addr);
    end
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 84; x++) begin
        drive(x < 80, 1'b0, 10'(x), 1'b0, -1);
        checks++;
        if ({rom_if.rom_rd, key_out} !== {1'b0, 10'd1023}) begin
          errors++; $display("FAIL post_rst_window: rd=%0b key=%0d expected 0/1023", rom_if.rom_rd, key_out);
        end
      end
    end
    probe_frame(busy);
    checks++; if (cap_addr !== 13'd0) begin errors++; $display("FAIL post_rst_addr: got %0d expected 0", cap_addr); end
    checks++; if ({cap_key, busy} !== {10'd992, 1'b1}) begin errors++; $display("FAIL post_rst_fade: key=%0d busy=%0b expected 992/1", cap_key, busy); end
  endtask

  initial begin
    rst = 1'b1; de_in = 1'b0; vs_in = 1'b0; data_in = '0; logo_en = 1'b0;
    rom_pix = '0; rom_alpha = '0;
    for (int i = 0; i < 3; i++) begin
      h_data[i] = '0; h_de[i] = 1'b0; h_vs[i] = 1'b0; h_hit[i] = 1'b0; h_tag[i] = -1;
    end
    test_reset();
    test_video_delay();
    test_on_window();
    test_fade_ramp();
    test_fade_out();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
